// File: rtl/wb_arb_pkg.sv
// Shared types for the two-master Wishbone arbiter: FSM states, master indices
// and the state-to-grant decode used for the debug grant vector.
package wb_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GNT0  = 2'd1,
    GNT1  = 2'd2,
    ABORT = 2'd3
  } arb_state_t;

  localparam int M0_IDX = 0;
  localparam int M1_IDX = 1;

  function automatic logic [1:0] grant_of(arb_state_t st);
    logic [1:0] g;
    g = 2'b00;
    if (st == GNT0) g = 2'b01;
    if (st == GNT1) g = 2'b10;
    return g;
  endfunction

endpackage

// File: rtl/wb_arbiter_if.sv
// One Wishbone B4 classic link; the arbiter uses slave views toward its masters
// and a master view toward the downstream interconnect.
interface wb_arbiter_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  // cyc frames a bus cycle, stb marks a beat inside it; a beat completes in the
  // cycle where the responder raises ack (or err) while stb is high.
  logic [ADDR_WIDTH-1:0]   adr;
  logic [DATA_WIDTH-1:0]   dat_w;
  logic [DATA_WIDTH-1:0]   dat_r;
  logic [DATA_WIDTH/8-1:0] sel;
  logic                    we;
  logic                    stb;
  logic                    cyc;
  logic                    ack;
  logic                    err;

  modport master (output adr, dat_w, sel, we, stb, cyc, input dat_r, ack, err);
  modport slave  (input adr, dat_w, sel, we, stb, cyc, output dat_r, ack, err);

endinterface

// File: rtl/wb_arb_watchdog.sv
// Stall watchdog: counts beat cycles without ACK and flags the last allowed one.
module wb_arb_watchdog #(
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clr,
  input  logic stb,
  input  logic ack,
  output logic expire
);

  localparam int CW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CW-1:0] LAST = CW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

  logic [CW-1:0] r_cnt;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_cnt <= '0;
    end else if (clr || ack || (TIMEOUT_CYCLES == 0)) begin
      r_cnt <= '0;
    end else if (stb) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  // An ACK in the expiry cycle completes the beat normally instead.
  assign expire = (TIMEOUT_CYCLES != 0) && stb && !ack && (r_cnt == LAST);

endmodule

// File: rtl/wb_arbiter.sv
// Two-master round-robin Wishbone arbiter with per-cycle grant, downstream mux
// and a watchdog that terminates stalled beats with ERR.
module wb_arbiter
  import wb_arb_pkg::*;
#(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic              clk_i,
  input  logic              rst_i,
  wb_arbiter_if.slave       m0,
  wb_arbiter_if.slave       m1,
  wb_arbiter_if.master      s,
  output logic [1:0]        grant_o,
  output arb_state_t        state_o
);

  arb_state_t r_state, w_state_nxt;
  logic       r_last, w_last_nxt;
  logic       w_gnt_stb;
  logic       w_wd_clr;
  logic       w_expire;

  logic [ADDR_WIDTH-1:0]   w_adr;
  logic [DATA_WIDTH-1:0]   w_dat_w;
  logic [DATA_WIDTH/8-1:0] w_sel;
  logic                    w_we;
  logic                    w_stb;
  logic                    w_cyc;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state <= IDLE;
      r_last  <= 1'(M1_IDX);
    end else begin
      r_state <= w_state_nxt;
      r_last  <= w_last_nxt;
    end
  end

  assign w_gnt_stb = ((r_state == GNT0) && m0.cyc && m0.stb) ||
                     ((r_state == GNT1) && m1.cyc && m1.stb);
  assign w_wd_clr  = (r_state != GNT0) && (r_state != GNT1);

  wb_arb_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .clr    (w_wd_clr),
    .stb    (w_gnt_stb),
    .ack    (s.ack),
    .expire (w_expire)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_last_nxt  = r_last;
    case (r_state)
      IDLE: begin
        if (m0.cyc && m1.cyc) begin
          w_state_nxt = (r_last == 1'(M0_IDX)) ? GNT1 : GNT0;
        end else if (m0.cyc) begin
          w_state_nxt = GNT0;
        end else if (m1.cyc) begin
          w_state_nxt = GNT1;
        end
      end
      GNT0: begin
        if (!m0.cyc) begin
          w_state_nxt = IDLE;
          w_last_nxt  = 1'(M0_IDX);
        end else if (w_expire) begin
          w_state_nxt = ABORT;
          w_last_nxt  = 1'(M0_IDX);
        end
      end
      GNT1: begin
        if (!m1.cyc) begin
          w_state_nxt = IDLE;
          w_last_nxt  = 1'(M1_IDX);
        end else if (w_expire) begin
          w_state_nxt = ABORT;
          w_last_nxt  = 1'(M1_IDX);
        end
      end
      ABORT: begin
        // r_last already names the aborted master; wait for it to drop CYC.
        if (!((r_last == 1'(M1_IDX)) ? m1.cyc : m0.cyc)) begin
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_comb begin
    w_adr   = '0;
    w_dat_w = '0;
    w_sel   = '0;
    w_we    = 1'b0;
    w_stb   = 1'b0;
    w_cyc   = 1'b0;
    case (r_state)
      GNT0: begin
        w_adr   = m0.adr;
        w_dat_w = m0.dat_w;
        w_sel   = m0.sel;
        w_we    = m0.we;
        w_stb   = m0.stb;
        w_cyc   = m0.cyc;
      end
      GNT1: begin
        w_adr   = m1.adr;
        w_dat_w = m1.dat_w;
        w_sel   = m1.sel;
        w_we    = m1.we;
        w_stb   = m1.stb;
        w_cyc   = m1.cyc;
      end
      default: ;
    endcase
  end

  assign s.adr   = w_adr;
  assign s.dat_w = w_dat_w;
  assign s.sel   = w_sel;
  assign s.we    = w_we;
  assign s.stb   = w_stb;
  assign s.cyc   = w_cyc;

  assign m0.dat_r = (r_state == GNT0) ? s.dat_r : '0;
  assign m0.ack   = (r_state == GNT0) && s.ack && m0.stb;
  assign m0.err   = (r_state == GNT0) && w_expire;
  assign m1.dat_r = (r_state == GNT1) ? s.dat_r : '0;
  assign m1.ack   = (r_state == GNT1) && s.ack && m1.stb;
  assign m1.err   = (r_state == GNT1) && w_expire;

  assign grant_o = grant_of(r_state);
  assign state_o = r_state;

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed bench for wb_arbiter: stimulus queues expected terminations, a
// negedge monitor pops and compares them; timing checks are done inline.
module tb_wb_arbiter;
  import wb_arb_pkg::*;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TO = 8;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] grant;
  arb_state_t state;

  wb_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) m0_if ();
  wb_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) m1_if ();
  wb_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) s_if ();

  wb_arbiter #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk_i   (clk),
    .rst_i   (rst),
    .m0      (m0_if),
    .m1      (m1_if),
    .s       (s_if),
    .grant_o (grant),
    .state_o (state)
  );

  // clock / reset
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  logic [33:0] exp_q[$];  // {master, err, data}

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic idle_all();
    m0_if.cyc = 0; m0_if.stb = 0; m0_if.we = 0; m0_if.adr = '0; m0_if.dat_w = '0; m0_if.sel = '0;
    m1_if.cyc = 0; m1_if.stb = 0; m1_if.we = 0; m1_if.adr = '0; m1_if.dat_w = '0; m1_if.sel = '0;
    s_if.ack = 0; s_if.err = 0; s_if.dat_r = '0;
  endtask

  task automatic req(input logic mst, input logic we, input logic [AW-1:0] adr, input logic [DW-1:0] d);
    if (mst) begin
      m1_if.cyc = 1; m1_if.stb = 1; m1_if.we = we; m1_if.adr = adr; m1_if.dat_w = d; m1_if.sel = '1;
    end else begin
      m0_if.cyc = 1; m0_if.stb = 1; m0_if.we = we; m0_if.adr = adr; m0_if.dat_w = d; m0_if.sel = '1;
    end
  endtask

  task automatic drop(input logic mst);
    if (mst) begin
      m1_if.cyc = 0; m1_if.stb = 0;
    end else begin
      m0_if.cyc = 0; m0_if.stb = 0;
    end
  endtask

  task automatic ack_beat(input logic mst, input logic [DW-1:0] d);
    exp_q.push_back({mst, 1'b0, d});
    s_if.ack = 1; s_if.dat_r = d;
    tick();
    s_if.ack = 0; s_if.dat_r = '0;
  endtask

  task automatic do_reset();
    rst = 1;
    idle_all();
    repeat (2) tick();
    rst = 0;
    tick();
  endtask

  // scoreboard monitor
  logic [33:0] mon_act;
  always @(negedge clk) begin
    if (!rst) begin
      chk("term_exclusive",
          {61'd0, m0_if.ack & m0_if.err, m1_if.ack & m1_if.err,
           (m0_if.ack | m0_if.err) & (m1_if.ack | m1_if.err)}, 64'd0);
      if (m0_if.ack || m0_if.err || m1_if.ack || m1_if.err) begin
        mon_act = (m0_if.ack || m0_if.err) ? {1'b0, m0_if.err, m0_if.dat_r}
                                           : {1'b1, m1_if.err, m1_if.dat_r};
        if (exp_q.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL unexpected_response: actual=%0h expected=none", mon_act);
        end else begin
          chk("response", mon_act, exp_q.pop_front());
        end
      end
    end
  end

  initial begin
    idle_all();
    rst = 1;
    repeat (2) tick();
    chk("rst_s_cyc", s_if.cyc, 0);
    chk("rst_s_stb", s_if.stb, 0);
    chk("rst_grant", grant, 0);
    chk("rst_state", state, IDLE);
    chk("rst_m0_ack", m0_if.ack, 0);
    rst = 0;
    tick();

    // single M0 read, slave ACKs two cycles after STB
    req(0, 0, 32'h0000_1000, '0);
    settle();
    chk("t1_latency", s_if.cyc, 0);
    tick();
    chk("t1_s_cyc", s_if.cyc, 1);
    chk("t1_grant", grant, 2'b01);
    chk("t1_adr", s_if.adr, 32'h0000_1000);
    tick();
    tick();
    ack_beat(0, 32'hDEAD_BEEF);
    drop(0);
    tick();
    chk("t1_release", grant, 0);

    // simultaneous requests after reset: M0, bubble, M1, then M0 again
    do_reset();
    req(0, 0, 32'h0000_2000, '0);
    req(1, 0, 32'h0000_3000, '0);
    tick();
    chk("t2_first_m0", grant, 2'b01);
    chk("t2_adr_m0", s_if.adr, 32'h0000_2000);
    ack_beat(0, 32'h1111_0000);
    drop(0);
    tick();
    chk("t2_bubble", grant, 0);
    tick();
    chk("t2_then_m1", grant, 2'b10);
    chk("t2_adr_m1", s_if.adr, 32'h0000_3000);
    ack_beat(1, 32'h2222_0000);
    drop(1);
    tick();
    req(0, 0, 32'h0000_2004, '0);
    req(1, 0, 32'h0000_3004, '0);
    tick();
    chk("t2_rr_m0_again", grant, 2'b01);
    ack_beat(0, 32'h3333_0000);
    drop(0);
    drop(1);
    tick();

    // M1 burst of four beats while M0 keeps requesting
    req(0, 1, 32'h0000_4000, 32'h0000_A5A5);
    req(1, 0, 32'h0000_5000, '0);
    tick();
    chk("t3_grant_m1", grant, 2'b10);
    for (int i = 0; i < 4; i++) begin
      ack_beat(1, 32'hB000_0000 + DW'(i));
      chk("t3_burst_hold", grant, 2'b10);
      chk("t3_burst_adr", s_if.adr, 32'h0000_5000);
    end
    drop(1);
    tick();
    chk("t3_bubble", grant, 0);
    tick();
    chk("t3_grant_m0", grant, 2'b01);
    chk("t3_we", s_if.we, 1);
    chk("t3_dat_w", s_if.dat_w, 32'h0000_A5A5);
    ack_beat(0, '0);
    drop(0);
    tick();
    tick();

    // watchdog expiry on an unanswered M0 write
    do_reset();
    req(0, 1, 32'h0000_6000, 32'h0000_1234);
    tick();
    exp_q.push_back({1'b0, 1'b1, 32'h0});
    for (int c = 0; c < TO; c++) begin
      chk("t4_err_timing", m0_if.err, 64'(c == TO - 1));
      chk("t4_s_cyc_held", s_if.cyc, 1);
      tick();
    end
    chk("t4_abort_cyc", s_if.cyc, 0);
    chk("t4_abort_stb", s_if.stb, 0);
    chk("t4_abort_grant", grant, 0);
    chk("t4_abort_state", state, ABORT);
    req(1, 0, 32'h0000_7000, '0);
    s_if.ack = 1; s_if.dat_r = 32'h0000_0BAD;
    settle();
    chk("t4_late_ack_m0", m0_if.ack, 0);
    chk("t4_late_ack_m1", m1_if.ack, 0);
    tick();
    s_if.ack = 0; s_if.dat_r = '0;
    chk("t4_abort_hold", state, ABORT);
    drop(0);
    tick();
    chk("t4_idle", state, IDLE);
    tick();
    chk("t4_m1_granted", grant, 2'b10);
    ack_beat(1, 32'hC0DE_0001);
    drop(1);
    tick();
    tick();

    // ACK arriving exactly in the expiry cycle wins
    do_reset();
    req(0, 0, 32'h0000_8000, '0);
    tick();
    repeat (TO - 1) tick();
    exp_q.push_back({1'b0, 1'b0, 32'h7777_7777});
    s_if.ack = 1; s_if.dat_r = 32'h7777_7777;
    settle();
    chk("t5_ack", m0_if.ack, 1);
    chk("t5_no_err", m0_if.err, 0);
    tick();
    s_if.ack = 0; s_if.dat_r = '0;
    chk("t5_state", state, GNT0);
    chk("t5_grant", grant, 2'b01);
    drop(0);
    tick();
    tick();

    // asynchronous reset in the middle of an M1 transfer
    do_reset();
    req(1, 0, 32'h0000_9000, '0);
    tick();
    chk("t6_grant_m1", grant, 2'b10);
    tick();
    #2;
    rst = 1;
    #1;
    chk("t6_async_cyc", s_if.cyc, 0);
    chk("t6_async_stb", s_if.stb, 0);
    chk("t6_async_grant", grant, 0);
    chk("t6_async_state", state, IDLE);
    req(0, 0, 32'h0000_A000, '0);
    repeat (2) tick();
    rst = 0;
    tick();
    chk("t6_m0_first", grant, 2'b01);
    drop(0);
    drop(1);
    tick();
    tick();

    chk("queue_drained", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
